// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: data-memory req/ack handshake, load/store lane formatting.
// Optional MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW skip memory and flag misalign_wb instead.
module mem_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] store_data_mem,
    input  logic [XLEN-1:0] pc_plus4_mem,
    input  logic [4:0]      rd_mem,
    input  logic            regwrite_mem,
    input  logic            memread_mem,
    input  logic            memwrite_mem,
    input  logic [2:0]      funct3_mem,
    input  logic            memtoreg_mem,
    input  logic            pc_to_reg_mem,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_mem,
    output logic            valid_wb,
    output logic [XLEN-1:0] alu_result_wb,
    output logic [XLEN-1:0] mem_load_data_wb,
    output logic [XLEN-1:0] pc_plus4_wb,
    output logic [4:0]      rd_wb,
    output logic            regwrite_wb,
    output logic            memtoreg_wb,
    output logic            pc_to_reg_wb,
    output logic            misalign_wb
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_off;
    logic [2:0]      r_funct3;
    logic            r_is_load;
    logic            r_regwrite, r_memtoreg, r_pc_to_reg;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu, r_pc4;

    logic            w_is_mem, w_is_load, w_misalign, w_issue;
    logic [1:0]      w_off;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata, w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_is_mem  = valid_mem & (memread_mem | memwrite_mem);
    assign w_is_load = memread_mem & ~memwrite_mem;
    assign w_off     = alu_result_mem[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_mem) begin
            case (funct3_mem)
                3'b001:  w_misalign = w_off[0];
                3'b101:  w_misalign = w_is_load & w_off[0];
                3'b010:  w_misalign = |w_off;
                default: w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_is_mem & ~w_misalign;

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = store_data_mem;
        case (funct3_mem)
            3'b000: begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{store_data_mem[7:0]}};
            end
            3'b001: begin
                w_wstrb = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{store_data_mem[15:0]}};
            end
            3'b010:  w_wstrb = 4'b1111;
            default: w_wstrb = 4'b0000;
        endcase
    end

    // Lane selection uses the offset latched at issue; rdata is only valid in the ack cycle.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall_mem    = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_mem = w_issue;
                if (w_issue) w_state_next = S_REQ;
            end
            S_REQ: begin
                stall_mem = ~dmem_ack;
                if (dmem_ack) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req <= 1'b0; dmem_we <= 1'b0; dmem_addr <= '0; dmem_wdata <= '0; dmem_wstrb <= 4'b0;
            r_off <= 2'b0; r_funct3 <= 3'b0; r_is_load <= 1'b0; r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0; r_pc_to_reg <= 1'b0; r_rd <= 5'd0; r_alu <= '0; r_pc4 <= '0;
            valid_wb <= 1'b0; alu_result_wb <= '0; mem_load_data_wb <= '0; pc_plus4_wb <= '0;
            rd_wb <= 5'd0; regwrite_wb <= 1'b0; memtoreg_wb <= 1'b0; pc_to_reg_wb <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_issue) begin
                dmem_req    <= 1'b1;
                dmem_we     <= memwrite_mem;
                dmem_addr   <= {alu_result_mem[XLEN-1:2], 2'b00};
                dmem_wdata  <= w_wdata;
                dmem_wstrb  <= memwrite_mem ? w_wstrb : 4'b0000;
                r_off       <= w_off;
                r_funct3    <= funct3_mem;
                r_is_load   <= w_is_load;
                r_regwrite  <= regwrite_mem;
                r_memtoreg  <= memtoreg_mem;
                r_pc_to_reg <= pc_to_reg_mem;
                r_rd        <= rd_mem;
                r_alu       <= alu_result_mem;
                r_pc4       <= pc_plus4_mem;
                valid_wb    <= 1'b0;
                regwrite_wb <= 1'b0;
            end else begin
                valid_wb         <= valid_mem;
                regwrite_wb      <= valid_mem & regwrite_mem & ~w_misalign;
                alu_result_wb    <= alu_result_mem;
                mem_load_data_wb <= '0;
                pc_plus4_wb      <= pc_plus4_mem;
                rd_wb            <= rd_mem;
                memtoreg_wb      <= memtoreg_mem;
                pc_to_reg_wb     <= pc_to_reg_mem;
            end
        end else if (dmem_ack) begin
            dmem_req         <= 1'b0;
            valid_wb         <= 1'b1;
            regwrite_wb      <= r_regwrite;
            alu_result_wb    <= r_alu;
            mem_load_data_wb <= r_is_load ? w_load : '0;
            pc_plus4_wb      <= r_pc4;
            rd_wb            <= r_rd;
            memtoreg_wb      <= r_memtoreg;
            pc_to_reg_wb     <= r_pc_to_reg;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    always_ff @(posedge clk) begin
        if (rst)                      r_misalign <= 1'b0;
        else if (r_state == S_IDLE)   r_misalign <= w_misalign;
        else                          r_misalign <= 1'b0;
    end
    assign misalign_wb = r_misalign;
`else
    assign misalign_wb = 1'b0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + randomized bench for mem_wb_stage with a transaction-level reference model.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem, regwrite_mem, memread_mem, memwrite_mem, memtoreg_mem, pc_to_reg_mem;
    logic [31:0] alu_result_mem, store_data_mem, pc_plus4_mem, dmem_rdata;
    logic [4:0]  rd_mem;
    logic [2:0]  funct3_mem;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall_mem, valid_wb, regwrite_wb, memtoreg_wb, pc_to_reg_wb, misalign_wb;
    logic [31:0] dmem_addr, dmem_wdata, alu_result_wb, mem_load_data_wb, pc_plus4_wb;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_wb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
        .store_data_mem(store_data_mem), .pc_plus4_mem(pc_plus4_mem), .rd_mem(rd_mem),
        .regwrite_mem(regwrite_mem), .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
        .funct3_mem(funct3_mem), .memtoreg_mem(memtoreg_mem), .pc_to_reg_mem(pc_to_reg_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .valid_wb(valid_wb), .alu_result_wb(alu_result_wb), .mem_load_data_wb(mem_load_data_wb),
        .pc_plus4_wb(pc_plus4_wb), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
        .memtoreg_wb(memtoreg_wb), .pc_to_reg_wb(pc_to_reg_wb), .misalign_wb(misalign_wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0:    return 4'(1 << int'(off));
            3'd1:    return 4'(3 << (2 * (int'(off) / 2)));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0:    return (sd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // One instruction presented in IDLE; memory ops get 'waits' no-ack cycles, then ack with rdata.
    task automatic run_op(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic p2r, input logic [31:0] pc4,
                          input int waits, input logic [31:0] rdata, input logic ack_idle);
        logic is_mem;
        logic [31:0] exp_ld;
        is_mem = v && (rd_en || wr_en);
        @(negedge clk);
        valid_mem = v; memread_mem = rd_en; memwrite_mem = wr_en; funct3_mem = f3;
        alu_result_mem = addr; store_data_mem = sd; rd_mem = rd; regwrite_mem = rw;
        memtoreg_mem = m2r; pc_to_reg_mem = p2r; pc_plus4_mem = pc4;
        dmem_ack = ack_idle; dmem_rdata = $urandom;
        #1 chk("stall_issue", 32'(stall_mem), 32'(is_mem));
        @(posedge clk); #1;
        if (is_mem) begin
            chk("req_set", 32'(dmem_req), 32'd1);
            chk("we", 32'(dmem_we), 32'(wr_en));
            chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            if (wr_en) chk("wstrb", 32'(dmem_wstrb), 32'(exp_strb(f3, addr[1:0])));
            if (wr_en && f3 <= 3'd2) chk("wdata", dmem_wdata, exp_wdata(f3, sd));
            chk("bubble_valid", 32'(valid_wb), 32'd0);
            chk("bubble_rw", 32'(regwrite_wb), 32'd0);
            for (int i = 0; i < waits; i++) begin
                @(negedge clk); dmem_ack = 1'b0; dmem_rdata = $urandom;
                #1 chk("stall_wait", 32'(stall_mem), 32'd1);
                @(posedge clk); #1;
                chk("req_hold", 32'(dmem_req), 32'd1);
                chk("addr_hold", dmem_addr, addr & 32'hFFFF_FFFC);
                chk("valid_wait", 32'(valid_wb), 32'd0);
            end
            @(negedge clk); dmem_ack = 1'b1; dmem_rdata = rdata;
            #1 chk("stall_ack", 32'(stall_mem), 32'd0);
            @(posedge clk); #1;
            exp_ld = (rd_en && !wr_en) ? exp_load(f3, addr[1:0], rdata) : 32'd0;
            chk("req_clr", 32'(dmem_req), 32'd0);
            chk("valid_wb", 32'(valid_wb), 32'd1);
            chk("regwrite_wb", 32'(regwrite_wb), 32'(rw));
            chk("load_data", mem_load_data_wb, exp_ld);
        end else begin
            chk("req_idle", 32'(dmem_req), 32'd0);
            chk("valid_wb", 32'(valid_wb), 32'(v));
            chk("regwrite_wb", 32'(regwrite_wb), 32'(v & rw));
            if (v) chk("load_data", mem_load_data_wb, 32'd0);
        end
        if (v) begin
            chk("alu_wb", alu_result_wb, addr);
            chk("rd_wb", 32'(rd_wb), 32'(rd));
            chk("pc4_wb", pc_plus4_wb, pc4);
            chk("ctl_wb", {30'd0, memtoreg_wb, pc_to_reg_wb}, {30'd0, m2r, p2r});
        end
        chk("misalign", 32'(misalign_wb), 32'd0);
        $display("op v=%0b rd=%0b wr=%0b f3=%0d addr=%h waits=%0d -> valid_wb=%0b load=%h",
                 v, rd_en, wr_en, f3, addr, waits, valid_wb, mem_load_data_wb);
    endtask

    initial begin
        rst = 1'b1; valid_mem = 0; regwrite_mem = 0; memread_mem = 0; memwrite_mem = 0;
        memtoreg_mem = 0; pc_to_reg_mem = 0; alu_result_mem = 0; store_data_mem = 0;
        pc_plus4_mem = 0; rd_mem = 0; funct3_mem = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_valid", 32'(valid_wb), 32'd0);
        chk("rst_alu", alu_result_wb, 32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        @(negedge clk); rst = 1'b0;

        // ADD
        run_op(1, 0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1, 0, 0, 32'h44, 0, 0, 0);
        // LB / LBU at 0x103 with 3 wait cycles
        run_op(1, 1, 0, 3'd0, 32'h103, 0, 5'd6, 1, 1, 0, 32'h48, 3, 32'h80FF_FF7F, 0);
        chk("lb_const", mem_load_data_wb, 32'hFFFF_FF80);
        run_op(1, 1, 0, 3'd4, 32'h103, 0, 5'd6, 1, 1, 0, 32'h4C, 3, 32'h80FF_FF7F, 0);
        chk("lbu_const", mem_load_data_wb, 32'h0000_0080);
        // SH at 0x202, immediate ack
        run_op(1, 0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 5'd0, 0, 0, 0, 32'h50, 0, 0, 0);
        chk("sh_strb_const", 32'(dmem_wstrb), 32'hC);
        chk("sh_wdata_const", dmem_wdata, 32'hBEEF_BEEF);

        // reset while a request is outstanding
        @(negedge clk);
        valid_mem = 1; memread_mem = 1; memwrite_mem = 0; funct3_mem = 3'd2;
        alu_result_mem = 32'h300; regwrite_mem = 1; dmem_ack = 0;
        @(posedge clk); #1 chk("rst_mid_req_set", 32'(dmem_req), 32'd1);
        @(negedge clk); rst = 1'b1; valid_mem = 0;
        @(posedge clk); #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_valid", 32'(valid_wb), 32'd0);
        @(negedge clk); rst = 1'b0;
        run_op(1, 0, 0, 3'd0, 32'h0000_0077, 0, 5'd9, 1, 0, 0, 32'h60, 0, 0, 0);

        // back-to-back LW then ADD, ack held high into IDLE
        run_op(1, 1, 0, 3'd2, 32'h10, 0, 5'd1, 1, 1, 0, 32'h64, 0, 32'hCAFE_F00D, 0);
        run_op(1, 0, 0, 3'd0, 32'h99, 0, 5'd2, 1, 0, 0, 32'h68, 0, 0, 1);
        run_op(0, 0, 0, 3'd0, 32'h0, 0, 5'd3, 1, 0, 0, 32'h6C, 0, 0, 1);
        // misaligned LW proceeds aligned-down
        run_op(1, 1, 0, 3'd2, 32'h102, 0, 5'd4, 1, 1, 0, 32'h70, 1, 32'h1234_5678, 0);
        chk("lw_mis_const", mem_load_data_wb, 32'h1234_5678);

        for (int n = 0; n < 150; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            run_op(($urandom_range(0, 9) != 0), (kind == 1 || kind == 3), (kind >= 2),
                   3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                   int'($urandom_range(0, 3)), $urandom, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus the MEM/WB pipeline register of the 5-stage RV32 core.
- Issues load/store transactions to data memory over a req/ack handshake.
- Aligns and extends load data, and registers all writeback-side signals (alu_result_wb, mem_load_data_wb, pc_plus4_wb, memtoreg_wb, pc_to_reg_wb, rd_wb, regwrite_wb) that feed the writeback mux.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
valid_mem  in  1  instruction in MEM is valid
alu_result_mem  in  32  ALU result; effective address for loads/stores
store_data_mem  in  32  rs2 value for stores
pc_plus4_mem  in  32  PC+4 of instruction
rd_mem  in  5  destination register
regwrite_mem  in  1  instruction writes rd
memread_mem  in  1  load
memwrite_mem  in  1  store
funct3_mem  in  3  access size/sign (RV32I encoding)
memtoreg_mem  in  1  writeback selects load data
pc_to_reg_mem  in  1  writeback selects PC+4
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  store data, lane-replicated
dmem_wstrb  out  4  byte-lane write strobes
dmem_ack  in  1  memory completes the request this cycle
dmem_rdata  in  32  read word, valid when dmem_ack=1
stall_mem  out  1  combinational; upstream must hold MEM inputs stable
valid_wb, alu_result_wb, mem_load_data_wb, pc_plus4_wb, rd_wb, regwrite_wb, memtoreg_wb, pc_to_reg_wb  out  1/32/32/32/5/1/1/1  MEM/WB register outputs
misalign_wb  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; every registered output, including dmem_*, goes to 0.
- A reset during REQ abandons the access. dmem_req is 0 from the next cycle. Memory must tolerate an abandoned request.
- FSM states: IDLE, REQ.
- IDLE, non-memory instruction (valid_mem and neither memread_mem nor memwrite_mem):
  - MEM/WB registers load the inputs on the next edge: 1-cycle latency.
  - mem_load_data_wb=0. stall_mem=0.
- IDLE, memory instruction (valid_mem and (memread_mem|memwrite_mem)):
  - stall_mem=1.
  - On the edge, latch dmem_addr, dmem_we, dmem_wdata, dmem_wstrb, byte offset, funct3 and writeback controls; set dmem_req=1; go to REQ.
  - valid_wb=0 and regwrite_wb=0 (bubble) for that edge.
- REQ, dmem_ack=0: dmem_* held constant; stall_mem=1; valid_wb=0.
- REQ, dmem_ack=1:
  - stall_mem=0 in the same cycle.
  - On the edge: dmem_req=0, load formatted dmem_rdata into mem_load_data_wb (0 for stores), valid_wb=1, go to IDLE.
  - Minimum memory-op latency is 2 cycles.
- dmem_ack outside REQ is ignored.
- valid_mem=0 in IDLE: valid_wb=0 and regwrite_wb=0 on the next edge.
- Load formatting (off=addr[1:0]):
  - LB: sign-extend byte[off]. LBU: zero-extend byte[off].
  - LH: sign-extend halfword[off[1]]. LHU: zero-extend halfword[off[1]].
  - LW: full word.
  - Reserved load funct3 values are treated as LW.
- Store formatting:
  - SB: wstrb=4'b0001<<off, wdata={4{b}}.
  - SH: wstrb=4'b0011<<(2*off[1]), wdata={2{h}}.
  - SW: wstrb=4'b1111.
  - Reserved store funct3: wstrb=0, handshake still performed.
- memread_mem and memwrite_mem both set: treated as a store, load data=0.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no request and causes no stall. Handled as a 1-cycle pass-through with valid_wb=1, regwrite_wb=0, misalign_wb=1.
- Undefined: misalign_wb is tied 0. Misaligned accesses proceed using the lane rules above: the word is aligned down, and LH uses halfword[off[1]].

Test Plan:
- ADD result 0x0000_1234, rd=5, regwrite=1 in IDLE -> next cycle valid_wb=1, alu_result_wb=0x1234, rd_wb=5, stall_mem never 1.
- LB addr 0x103, rdata 0x80FF_FF7F, ack after 3 REQ cycles -> dmem_addr=0x100; stall_mem=1 for 4 cycles; mem_load_data_wb=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH addr 0x202, data 0x0000_BEEF, ack immediate -> dmem_we=1, wstrb=4'b1100, wdata=0xBEEF_BEEF; valid_wb=1 two cycles after issue; dmem_req held stable until ack.
- rst asserted during REQ (no ack) -> next cycle dmem_req=0, valid_wb=0, state IDLE; a following ADD completes in 1 cycle.
- Back-to-back LW 0x10 then ADD with 0-wait ack -> ADD held by stall_mem, reaches WB exactly one cycle after the LW; ack asserted in IDLE is ignored.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x102 -> no dmem_req, misalign_wb=1, regwrite_wb=0 next cycle; without the macro: request to 0x100, full word returned.
